pipelined_loop_ctrl: RTL and testbench
======================================

Name: pipelined_loop_ctrl

Overview:
Loop-issue controller that sits directly downstream of the start/II counting primitives. It consumes a one-cycle start pulse and issues TRIP_COUNT loop iterations, one every II cycles. It tracks occupancy of a DEPTH-stage datapath pipeline and pulses done when the final iteration leaves the last stage. A global stall freezes all issue and pipeline state.

Parameters:
TRIP_COUNT, 4, iterations per loop invocation; legal range >= 1.
II, 1, initiation interval in clocks between successive issues; legal range >= 1.
DEPTH, 3, number of datapath pipeline stages tracked; legal range >= 1.
IDX_W, 32, width of iteration index and internal counters.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, synchronous, active-high.
start  in  1  invocation request; sampled only in IDLE with stall low.
stall  in  1  freeze: no issue, no counter or pipeline advance.
issue  out  1  an iteration enters stage 0 this cycle.
iter_idx  out  IDX_W  index of the issuing iteration, 0..TRIP_COUNT-1; valid when issue is high, otherwise holds the last value.
last_iter  out  1  issue && iter_idx == TRIP_COUNT-1.
stage_valid  out  DEPTH  bit k high means stage k holds an iteration this cycle.
busy  out  1  invocation in progress, including the accepting start cycle and the done cycle.
done  out  1  one-cycle pulse when the final iteration occupies stage DEPTH-1 with stall low.

Behaviour:
- Reset values:
  - state = IDLE; issue, last_iter, busy and done = 0.
  - stage_valid = 0; iter_idx = 0; internal II timer and issue count = 0.
  - rst has priority over all inputs. Reset mid-operation aborts the invocation with no done pulse.
- States:
  - IDLE -> ISSUE on start && !stall.
  - ISSUE -> DRAIN after the last issue, when DEPTH > 1.
  - ISSUE/DRAIN -> IDLE in the done cycle.
- Issue timing:
  - Issue is combinational: in the accepting cycle (IDLE, start, !stall), issue = 1 and iter_idx = 0, with zero latency from start.
  - Each subsequent issue follows exactly II non-stalled cycles after the previous one. Stalled cycles do not count.
  - With II = 1, issue is high on consecutive non-stalled cycles.
- Stage tracking:
  - stage_valid[0] = issue.
  - For k >= 1, stage_valid[k] is a register loaded from stage_valid[k-1] on each non-stalled cycle and held while stalled.
  - Multiple bits may be set when II < DEPTH.
- Completion:
  - done = stage_valid[DEPTH-1] && !stall && (the iteration in that stage is the last one). This is tracked by shifting a last_iter flag alongside stage_valid.
  - With DEPTH = 1, done coincides with the last issue.
- Stall:
  - issue, last_iter and done are forced to 0 while stall is high. All registers hold.
  - busy stays high while stalled.
- Ignored and dropped starts:
  - start in ISSUE, DRAIN or the done cycle is ignored.
  - start with stall high in IDLE is dropped; the requester must re-assert it.
- Arithmetic:
  - Counters are unsigned IDX_W bits. Compare against TRIP_COUNT-1 and II-1; no wrap occurs for legal parameters.
- Parameter checks: elaboration-time error if TRIP_COUNT, II or DEPTH is below 1.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ISSUE, DRAIN), 2 bits;
  - the IDX_W default;
  - a parameter-check macro or function reused by the sibling loop blocks.
- One natural sub-module, ii_timer:
  - Ports: clk, rst, load, stall; output fire.
  - Parameter II.
  - Counts II non-stalled cycles after load and pulses fire.

Test Plan:
1. TRIP_COUNT=4, II=1, DEPTH=3, start at cycle 0.
   -> issue at cycles 0-3 with iter_idx 0,1,2,3; last_iter at cycle 3; done only at cycle 5; busy cycles 0-5; IDLE at cycle 6.
2. TRIP_COUNT=2, II=3, DEPTH=2, start at cycle 0.
   -> issue at cycles 0 and 3; stage_valid = 01,10,00,01,10 on cycles 0-4; done at cycle 4.
3. Config 1 with stall high at cycles 2-3.
   -> issue at cycles 0,1,4,5; stage_valid frozen during the stall; done at cycle 7; no issue or done while stalled.
4. TRIP_COUNT=1, DEPTH=1.
   -> start at cycle 0 gives issue, last_iter and done all at cycle 0; busy for 1 cycle.
5. Config 1 with rst at cycle 2.
   -> all outputs 0 at cycle 3; no done pulse; a new start at cycle 4 issues iter_idx=0 at cycle 4.
6. Config 1 with start re-pulsed at cycles 2 and 5.
   -> both ignored and no second invocation; start at cycle 0 with stall high is dropped, busy stays 0.

Source files
------------

// File: rtl/pipelined_loop_ctrl_pkg.sv
// Shared definitions for the loop-issue controller family: state encoding,
// default index width and the parameter sanity check used at elaboration.
package pipelined_loop_ctrl_pkg;

    localparam int IDX_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } loop_state_e;

    function automatic bit param_ok(input int value);
        return value >= 1;
    endfunction

endpackage

// File: rtl/pipelined_loop_ctrl_ii_timer.sv
// Initiation-interval timer: after load, fire rises once II non-stalled
// cycles have elapsed and stays up until a non-stalled cycle consumes it.
module pipelined_loop_ctrl_ii_timer
    import pipelined_loop_ctrl_pkg::*;
#(
    parameter int II = 1,
    parameter int W  = IDX_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic stall_i,
    output logic fire_o
);

    if (!param_ok(II)) begin : g_bad_ii
        $error("pipelined_loop_ctrl_ii_timer: II must be >= 1");
    end

    logic [W-1:0] rem_q, rem_d;
    logic         armed_q, armed_d;

    assign fire_o = armed_q && (rem_q == '0);

    // A reload wins over consuming the pending fire, so back-to-back issues chain.
    always_comb begin
        rem_d   = rem_q;
        armed_d = armed_q;
        if (load_i) begin
            rem_d   = W'(II - 1);
            armed_d = 1'b1;
        end else if (armed_q && !stall_i) begin
            if (fire_o) begin
                armed_d = 1'b0;
            end else begin
                rem_d = rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/pipelined_loop_ctrl.sv
// Loop-issue controller: issues TRIP_COUNT iterations one every II cycles,
// tracks their flight through a DEPTH-stage pipeline and pulses done on exit.
module pipelined_loop_ctrl
    import pipelined_loop_ctrl_pkg::*;
#(
    parameter int TRIP_COUNT = 4,
    parameter int II         = 1,
    parameter int DEPTH      = 3,
    parameter int IDX_W      = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stall_i,
    output logic             issue_o,
    output logic [IDX_W-1:0] iter_idx_o,
    output logic             last_iter_o,
    output logic [DEPTH-1:0] stage_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    if (!param_ok(TRIP_COUNT) || !param_ok(II) || !param_ok(DEPTH)) begin : g_bad_param
        $error("pipelined_loop_ctrl: TRIP_COUNT, II and DEPTH must be >= 1");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRIP_COUNT - 1);
    localparam int               PW       = (DEPTH > 1) ? DEPTH - 1 : 1;

    loop_state_e      state_q, state_d;
    logic [IDX_W-1:0] issued_q, issued_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PW-1:0]    vpipe_q, vpipe_d;
    logic [PW-1:0]    lpipe_q, lpipe_d;
    logic [DEPTH-1:0] last_flags;
    logic             fire;
    logic             accept;
    logic [IDX_W-1:0] cur_idx;

    pipelined_loop_ctrl_ii_timer #(
        .II (II),
        .W  (IDX_W)
    ) u_ii_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (issue_o),
        .stall_i (stall_i),
        .fire_o  (fire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            issued_q <= '0;
            idx_q    <= '0;
            vpipe_q  <= '0;
            lpipe_q  <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            idx_q    <= idx_d;
            vpipe_q  <= vpipe_d;
            lpipe_q  <= lpipe_d;
        end
    end

    // Next state; every transition is qualified by an unstalled output event.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        idx_d    = idx_q;
        if (done_o) begin
            state_d = ST_IDLE;
        end else if (last_iter_o) begin
            state_d = ST_DRAIN;
        end else if (accept) begin
            state_d = ST_ISSUE;
        end
        if (issue_o) begin
            issued_d = cur_idx + 1'b1;
            idx_d    = cur_idx;
        end
    end

    // Outputs; the accepting cycle issues iteration 0 with no latency.
    always_comb begin
        accept      = (state_q == ST_IDLE) && start_i && !stall_i;
        cur_idx     = accept ? '0 : issued_q;
        issue_o     = accept || ((state_q == ST_ISSUE) && fire && !stall_i);
        iter_idx_o  = issue_o ? cur_idx : idx_q;
        last_iter_o = issue_o && (cur_idx == LAST_IDX);
        busy_o      = (state_q != ST_IDLE) || accept;
        state_o     = state_q;
    end

    if (DEPTH > 1) begin : g_pipe
        assign stage_valid_o = {vpipe_q, issue_o};
        assign last_flags    = {lpipe_q, last_iter_o};
        assign vpipe_d       = stall_i ? vpipe_q : stage_valid_o[DEPTH-2:0];
        assign lpipe_d       = stall_i ? lpipe_q : last_flags[DEPTH-2:0];
    end else begin : g_no_pipe
        assign stage_valid_o = issue_o;
        assign last_flags    = last_iter_o;
        assign vpipe_d       = '0;
        assign lpipe_d       = '0;
    end

    assign done_o = stage_valid_o[DEPTH-1] && last_flags[DEPTH-1] && !stall_i;

endmodule

// File: tb/tb_pipelined_loop_ctrl.sv
// Bench for pipelined_loop_ctrl: four parameterisations share one random
// start/stall/rst stream and are checked cycle by cycle against a timing model.
module tb_pipelined_loop_ctrl;

    localparam int NI = 4;
    localparam int RW = 44;

    function automatic int tc_of(input int g);
        case (g)
            0: return 4;
            1: return 2;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int ii_of(input int g);
        case (g)
            0: return 1;
            1: return 3;
            2: return 2;
            default: return 2;
        endcase
    endfunction

    function automatic int dp_of(input int g);
        case (g)
            0: return 3;
            1: return 2;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    logic clk;
    logic rst;
    logic start;
    logic stall;

    logic [RW-1:0] act_w [NI];
    logic [1:0]    state_w [NI];

    // record layout: {issue, iter_idx[31:0], last_iter, stage_valid[7:0], busy, done}
    logic [NI*RW-1:0] exp_q[$];

    logic        m_active [NI];
    int          m_t      [NI];
    logic [31:0] m_idx    [NI];

    int tests_run;
    int tests_failed;
    int cyc;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DP = dp_of(g);
        logic          issue;
        logic [31:0]   idx;
        logic          last;
        logic [DP-1:0] sv;
        logic          busy;
        logic          done;

        pipelined_loop_ctrl #(
            .TRIP_COUNT (tc_of(g)),
            .II         (ii_of(g)),
            .DEPTH      (DP),
            .IDX_W      (32)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .start_i       (start),
            .stall_i       (stall),
            .issue_o       (issue),
            .iter_idx_o    (idx),
            .last_iter_o   (last),
            .stage_valid_o (sv),
            .busy_o        (busy),
            .done_o        (done),
            .state_o       (state_w[g])
        );

        assign act_w[g] = {issue, idx, last, 8'(sv), busy, done};
    end

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: t counts unstalled cycles since the accepting cycle. Iteration i
    // sits in stage k when t == i*II + k; the last one leaves at (TC-1)*II + DEPTH-1.
    task automatic drive(input logic s, input logic st, input logic r);
        logic [NI*RW-1:0] rec;
        @(posedge clk);
        #1;
        start = s;
        stall = st;
        rst   = r;
        rec   = '0;
        for (int g = 0; g < NI; g++) begin
            int          tc;
            int          iv;
            int          dp;
            int          t;
            int          d;
            logic        act;
            logic        iss;
            logic        dn;
            logic [31:0] idx;
            logic [7:0]  sv;
            tc  = tc_of(g);
            iv  = ii_of(g);
            dp  = dp_of(g);
            act = m_active[g];
            t   = m_t[g];
            if (!act && s && !st) begin
                act = 1'b1;
                t   = 0;
            end
            sv = '0;
            for (int k = 0; k < dp; k++) begin
                d = t - k;
                if (act && d >= 0 && (d % iv) == 0 && (d / iv) < tc && (k > 0 || !st))
                    sv[k] = 1'b1;
            end
            iss = sv[0];
            idx = iss ? 32'(t / iv) : m_idx[g];
            dn  = act && !st && (t == (tc - 1) * iv + dp - 1);
            rec[g*RW +: RW] = {iss, idx, iss && (idx == 32'(tc - 1)), sv, act, dn};
            if (r) begin
                m_active[g] = 1'b0;
                m_t[g]      = 0;
                m_idx[g]    = '0;
            end else begin
                m_idx[g]    = idx;
                m_active[g] = act && !dn;
                m_t[g]      = (act && !st) ? t + 1 : t;
            end
        end
        exp_q.push_back(rec);
    endtask

    task automatic run(input logic s, input logic st, input logic r, input int n);
        for (int i = 0; i < n; i++) drive(s, st, r);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [NI*RW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int g = 0; g < NI; g++) begin
                tests_run++;
                if (act_w[g] !== e[g*RW +: RW]) begin
                    tests_failed++;
                    $display("FAIL inst%0d cyc%0d {issue,idx,last,stage,busy,done}: got %h want %h",
                             g, cyc, act_w[g], e[g*RW +: RW]);
                end
            end
            cyc++;
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        for (int g = 0; g < NI; g++) begin
            m_active[g] = 1'b0;
            m_t[g]      = 0;
            m_idx[g]    = '0;
        end
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);

        // directed: reset state, dropped start, re-pulses, stall, mid-run reset
        run(0, 0, 0, 1);
        run(1, 1, 0, 1);
        run(0, 0, 0, 2);
        run(1, 0, 0, 1);
        run(0, 0, 0, 1);
        run(1, 0, 0, 1);
        run(0, 1, 0, 2);
        run(0, 0, 0, 1);
        run(1, 0, 0, 1);
        run(0, 0, 0, 10);
        run(1, 0, 0, 1);
        run(0, 0, 0, 1);
        run(0, 0, 1, 1);
        run(0, 0, 0, 1);
        run(1, 0, 0, 1);
        run(0, 0, 0, 14);
        run(1, 0, 0, 1);
        run(1, 0, 0, 20);

        for (int i = 0; i < 2500; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 149) == 0));
        end

        run(0, 0, 0, 16);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
